// File: rtl/usb_pkg.sv
// usb_pkg: shared USB constants and types for the endpoint 0 controller.
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam int TOK_PID_LSB  = 0;
  localparam int TOK_ADDR_LSB = 8;
  localparam int TOK_ENDP_LSB = 15;
  localparam int TOK_CRC_LSB  = 19;

  localparam logic [7:0] REQ_SET_ADDRESS = 8'h05;
  localparam int         SETUP_BUF_LEN   = 8;

  typedef enum logic [1:0] {
    IDLE,
    RX_DATA,
    TX_HS,
    TX_ZLP
  } ep_state_e;

  typedef enum logic [1:0] {
    REQ_SET_ADDR,
    REQ_NO_DATA,
    REQ_UNSUPPORTED
  } req_class_e;

  // Field order matches the token bus: CRC5 in the top bits, PID in the bottom byte.
  typedef struct packed {
    logic [4:0] crc;
    logic [3:0] endp;
    logic [6:0] addr;
    logic [7:0] pid;
  } token_t;

  // A PID is only trusted when its upper nibble is the complement of the lower one.
  function automatic logic pidOk(input logic [7:0] p);
    return p[7:4] == ~p[3:0];
  endfunction

endpackage

// File: rtl/setup_decoder.sv
// setup_decoder: classifies a captured 8-byte SETUP payload into the request
// kinds endpoint 0 can answer and extracts the SET_ADDRESS target address.
module setup_decoder
  import usb_pkg::*;
(
  input  logic [SETUP_BUF_LEN-1:0][7:0] setupBuf_i,
  output req_class_e                    reqClass_o,
  output logic [6:0]                    addrValue_o
);

  logic [7:0]  bmRequestType;
  logic [7:0]  bRequest;
  logic [15:0] wLength;
  logic        unusedBits;

  assign bmRequestType = setupBuf_i[0];
  assign bRequest      = setupBuf_i[1];
  assign wLength       = {setupBuf_i[7], setupBuf_i[6]};
  assign addrValue_o   = setupBuf_i[2][6:0];
  assign unusedBits    = ^{setupBuf_i[2][7], setupBuf_i[3], setupBuf_i[4], setupBuf_i[5]};

  // SET_ADDRESS first, then any host-to-device request without a data stage; everything else stalls.
  always_comb begin
    reqClass_o = REQ_UNSUPPORTED;
    if (bmRequestType == 8'h00 && bRequest == REQ_SET_ADDRESS) begin
      reqClass_o = REQ_SET_ADDR;
    end else if (!bmRequestType[7] && wLength == 16'h0000) begin
      reqClass_o = REQ_NO_DATA;
    end
  end

endmodule

// File: rtl/endpoint_ctrl.sv
// endpoint_ctrl: USB device control endpoint 0. Accepts tokens addressed to
// this device/EP0, captures SETUP payloads, answers with ACK/NAK/STALL or a
// zero-length DATA1 status packet, and applies SET_ADDRESS after its status stage.
module endpoint_ctrl
  import usb_pkg::*;
#(
  parameter logic [6:0] RESET_ADDR = 7'd0,
  parameter int         SETUP_LEN  = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [23:0] token_in,
  input  logic        token_in_strb,
  input  logic [7:0]  data_in,
  input  logic        data_in_strb,
  input  logic        data_in_end,
  input  logic        data_in_fail,
  input  logic [7:0]  pid,
  output logic [7:0]  data_o,
  output logic        data_o_start_stop,
  input  logic        data_o_strb,
  input  logic        data_o_fail
);

  localparam logic [3:0] LEN_FULL = 4'(SETUP_LEN);
  localparam logic [3:0] CNT_SAT  = 4'(SETUP_LEN + 1);
  localparam logic [3:0] BUF_LEN  = 4'(SETUP_BUF_LEN);

  ep_state_e                     state_q;
  logic [6:0]                    addr_q;
  logic [6:0]                    pendAddr_q;
  logic                          pendValid_q;
  logic                          statusPending_q;
  logic                          stall_q;
  logic                          toggle_q;
  logic                          setupMode_q;
  logic [3:0]                    count_q;
  logic [SETUP_BUF_LEN-1:0][7:0] setupBuf_q;
  logic [7:0]                    dataO_q;
  logic                          startStop_q;

  token_t     tok;
  logic       tokenHit;
  logic [7:0] expectPid;
  req_class_e reqClass;
  logic [6:0] reqAddr;
  logic       unusedBits;

  assign tok               = token_t'(token_in);
  assign unusedBits        = ^tok.crc;
  assign expectPid         = toggle_q ? PID_DATA1 : PID_DATA0;
  assign data_o            = dataO_q;
  assign data_o_start_stop = startStop_q;

  setup_decoder uSetupDecoder (
    .setupBuf_i  (setupBuf_q),
    .reqClass_o  (reqClass),
    .addrValue_o (reqAddr)
  );

  // A token is ours when its PID is self-consistent, it is not a SOF, and it targets this address on EP0.
  always_comb begin
    tokenHit = pidOk(tok.pid) && (tok.pid != PID_SOF) &&
               (tok.addr == addr_q) && (tok.endp == 4'd0);
  end

  // Endpoint FSM with registered transmitter outputs; any token strobe aborts the current packet and is evaluated at once.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q         <= IDLE;
      addr_q          <= RESET_ADDR;
      pendAddr_q      <= 7'd0;
      pendValid_q     <= 1'b0;
      statusPending_q <= 1'b0;
      stall_q         <= 1'b0;
      toggle_q        <= 1'b0;
      setupMode_q     <= 1'b0;
      count_q         <= 4'd0;
      setupBuf_q      <= '0;
      dataO_q         <= 8'h00;
      startStop_q     <= 1'b0;
    end else if (token_in_strb) begin
      state_q     <= IDLE;
      dataO_q     <= 8'h00;
      startStop_q <= 1'b0;
      if (tokenHit) begin
        case (tok.pid)
          PID_SETUP, PID_OUT: begin
            state_q     <= RX_DATA;
            setupMode_q <= (tok.pid == PID_SETUP);
            count_q     <= 4'd0;
          end
          PID_IN: begin
            startStop_q <= 1'b1;
            if (stall_q) begin
              state_q <= TX_HS;
              dataO_q <= PID_STALL;
            end else if (statusPending_q) begin
              state_q <= TX_ZLP;
              dataO_q <= PID_DATA1;
              count_q <= 4'd0;
            end else begin
              state_q <= TX_HS;
              dataO_q <= PID_NAK;
            end
          end
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        RX_DATA: begin
          if (data_in_fail) begin
            state_q <= IDLE;
          end else if (data_in_end) begin
            state_q <= IDLE;
            if (setupMode_q) begin
              if (pid == PID_DATA0 && count_q == LEN_FULL) begin
                state_q         <= TX_HS;
                dataO_q         <= PID_ACK;
                startStop_q     <= 1'b1;
                toggle_q        <= 1'b1;
                stall_q         <= (reqClass == REQ_UNSUPPORTED);
                statusPending_q <= (reqClass != REQ_UNSUPPORTED);
                if (reqClass == REQ_SET_ADDR) begin
                  pendAddr_q  <= reqAddr;
                  pendValid_q <= 1'b1;
                end
              end
            end else if (stall_q) begin
              state_q     <= TX_HS;
              dataO_q     <= PID_STALL;
              startStop_q <= 1'b1;
            end else if (pid == PID_DATA0 || pid == PID_DATA1) begin
              state_q     <= TX_HS;
              dataO_q     <= PID_ACK;
              startStop_q <= 1'b1;
              if (pid == expectPid) begin
                toggle_q <= ~toggle_q;
              end
            end
          end else if (data_in_strb) begin
            if (count_q < BUF_LEN) begin
              setupBuf_q[count_q[2:0]] <= data_in;
            end
            if (count_q != CNT_SAT) begin
              count_q <= count_q + 4'd1;
            end
          end
        end
        TX_HS: begin
          if (data_o_strb || data_o_fail) begin
            state_q     <= IDLE;
            dataO_q     <= 8'h00;
            startStop_q <= 1'b0;
          end
        end
        TX_ZLP: begin
          if (data_o_fail) begin
            state_q     <= IDLE;
            dataO_q     <= 8'h00;
            startStop_q <= 1'b0;
          end else if (data_o_strb) begin
            dataO_q <= 8'h00;
            if (count_q == 4'd2) begin
              state_q         <= IDLE;
              startStop_q     <= 1'b0;
              statusPending_q <= 1'b0;
              if (pendValid_q) begin
                addr_q      <= pendAddr_q;
                pendValid_q <= 1'b0;
              end
            end else begin
              count_q <= count_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_endpoint_ctrl.sv
// tb_endpoint_ctrl: directed and randomized transactions against endpoint_ctrl,
// checked against a transaction-level model of the endpoint 0 protocol rules.
module tb_endpoint_ctrl;

  localparam logic [7:0] P_OUT   = 8'hE1;
  localparam logic [7:0] P_IN    = 8'h69;
  localparam logic [7:0] P_SOF   = 8'hA5;
  localparam logic [7:0] P_SETUP = 8'h2D;
  localparam logic [7:0] P_DATA0 = 8'hC3;
  localparam logic [7:0] P_DATA1 = 8'h4B;
  localparam logic [7:0] P_ACK   = 8'hD2;
  localparam logic [7:0] P_NAK   = 8'h5A;
  localparam logic [7:0] P_STALL = 8'h1E;

  logic        clk = 1'b0;
  logic        nrst;
  logic [23:0] token_in;
  logic        token_in_strb;
  logic [7:0]  data_in;
  logic        data_in_strb;
  logic        data_in_end;
  logic        data_in_fail;
  logic [7:0]  pid;
  logic [7:0]  data_o;
  logic        data_o_start_stop;
  logic        data_o_strb;
  logic        data_o_fail;

  int checks = 0;
  int errors = 0;

  logic [7:0] payload [10];
  logic [7:0] rx [6];
  logic [7:0] expB [3];

  logic [6:0] mAddr;
  logic [6:0] mPendAddr;
  bit         mPendValid;
  bit         mStatus;
  bit         mStall;
  logic [7:0] mToggle;

  endpoint_ctrl #(.RESET_ADDR(7'd0), .SETUP_LEN(8)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .token_in          (token_in),
    .token_in_strb     (token_in_strb),
    .data_in           (data_in),
    .data_in_strb      (data_in_strb),
    .data_in_end       (data_in_end),
    .data_in_fail      (data_in_fail),
    .pid               (pid),
    .data_o            (data_o),
    .data_o_start_stop (data_o_start_stop),
    .data_o_strb       (data_o_strb),
    .data_o_fail       (data_o_fail)
  );

  always #5 clk = ~clk;

  // Hard stop in case the DUT or bench wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mAddr = 7'd0; mPendAddr = 7'd0; mPendValid = 0; mStatus = 0; mStall = 0; mToggle = P_DATA0;
  endtask

  task automatic resetDut();
    nrst = 1'b1; token_in = '0; token_in_strb = 0; data_in = '0; data_in_strb = 0;
    data_in_end = 0; data_in_fail = 0; pid = '0; data_o_strb = 0; data_o_fail = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    modelReset();
  endtask

  function automatic logic [23:0] mkTok(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e);
    return {5'($urandom_range(0, 31)), e, a, p};
  endfunction

  // Protocol-level expectation for one transaction; returns the bytes the host side should see.
  task automatic modelStep(input logic [23:0] tok, input int nBytes, input logic [7:0] dpid,
                           input int endMode, input int failAt, output int expN);
    logic [7:0] tp;
    logic [15:0] wLen;
    bit ours;
    bit zlp;
    tp = tok[7:0];
    ours = (tp[7:4] == ~tp[3:0]) && (tp != P_SOF) && (tok[14:8] == mAddr) && (tok[18:15] == 4'd0);
    expN = 0; zlp = 0;
    expB[0] = 8'h00; expB[1] = 8'h00; expB[2] = 8'h00;
    if (!ours) return;
    if (tp == P_SETUP) begin
      if (endMode != 0 || dpid != P_DATA0 || nBytes != 8) return;
      expN = 1; expB[0] = P_ACK; mStall = 0; mToggle = P_DATA1;
      wLen = {payload[7], payload[6]};
      if (payload[0] == 8'h00 && payload[1] == 8'h05) begin
        mPendAddr = payload[2][6:0]; mPendValid = 1; mStatus = 1;
      end else if (payload[0] < 8'h80 && wLen == 16'h0) begin
        mStatus = 1;
      end else begin
        mStall = 1; mStatus = 0;
      end
    end else if (tp == P_OUT) begin
      if (endMode != 0) return;
      if (mStall) begin
        expN = 1; expB[0] = P_STALL;
      end else if (dpid == P_DATA0 || dpid == P_DATA1) begin
        expN = 1; expB[0] = P_ACK;
        if (dpid == mToggle) mToggle = (mToggle == P_DATA0) ? P_DATA1 : P_DATA0;
      end
    end else if (tp == P_IN) begin
      if (mStall) begin
        expN = 1; expB[0] = P_STALL;
      end else if (mStatus) begin
        expN = 3; expB[0] = P_DATA1; zlp = 1;
      end else begin
        expN = 1; expB[0] = P_NAK;
      end
    end
    if (failAt >= 0 && failAt < expN) begin
      expN = failAt;
    end else if (zlp) begin
      mStatus = 0;
      if (mPendValid) begin mAddr = mPendAddr; mPendValid = 0; end
    end
  endtask

  task automatic sendToken(input logic [23:0] tok);
    token_in = tok; token_in_strb = 1;
    @(negedge clk);
    token_in_strb = 0;
  endtask

  // Plays the transmitter: waits for a packet, consumes bytes with random gaps, optionally aborts at byte failAt.
  task automatic collect(input string tag, input int failAt, output int n);
    int waited;
    int gap;
    logic [7:0] hold;
    n = 0; waited = 0;
    while (!data_o_start_stop && waited < 4) begin
      @(negedge clk); waited++;
    end
    while (data_o_start_stop && n < 6) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        hold = data_o;
        @(negedge clk);
        checkOutput({tag, ".hold"}, 32'(data_o), 32'(hold));
      end
      rx[n] = data_o;
      if (n == failAt) begin
        data_o_fail = 1; @(negedge clk); data_o_fail = 0;
        checkOutput({tag, ".failDrop"}, 32'(data_o_start_stop), 32'd0);
        break;
      end
      data_o_strb = 1; @(negedge clk); data_o_strb = 0;
      n++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [23:0] tok, input int nBytes,
                               input logic [7:0] dpid, input int endMode, input int failAt);
    int n;
    int expN;
    sendToken(tok);
    if (tok[7:0] == P_SETUP || tok[7:0] == P_OUT) begin
      for (int i = 0; i < nBytes; i++) begin
        data_in = payload[i]; data_in_strb = 1; @(negedge clk); data_in_strb = 0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      if (endMode == 0) begin
        pid = dpid; data_in_end = 1; @(negedge clk); data_in_end = 0;
      end else if (endMode == 1) begin
        data_in_fail = 1; @(negedge clk); data_in_fail = 0;
      end
    end
    collect(tag, failAt, n);
    @(negedge clk);
    checkOutput({tag, ".idleSS"}, 32'(data_o_start_stop), 32'd0);
    checkOutput({tag, ".idleData"}, 32'(data_o), 32'd0);
    modelStep(tok, nBytes, dpid, endMode, failAt, expN);
    checkOutput({tag, ".len"}, 32'(n), 32'(expN));
    for (int i = 0; i < expN && i < n; i++)
      checkOutput($sformatf("%s.byte%0d", tag, i), 32'(rx[i]), 32'(expB[i]));
  endtask

  task automatic setPayload(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b6);
    for (int i = 0; i < 10; i++) payload[i] = 8'h00;
    payload[0] = b0; payload[1] = b1; payload[2] = b2; payload[6] = b6;
  endtask

  initial begin
    int kind;
    int nB;
    int em;
    int fa;
    logic [7:0] dp;
    logic [7:0] tp;
    logic [23:0] tok;

    resetDut();
    checkOutput("reset.data", 32'(data_o), 32'd0);
    checkOutput("reset.ss", 32'(data_o_start_stop), 32'd0);

    // SET_ADDRESS(7) then status stage, then the new address takes effect
    setPayload(8'h00, 8'h05, 8'h07, 8'h00);
    applyStimulus("setAddr", 24'hF8002D, 8, P_DATA0, 0, -1);
    applyStimulus("statusZlp", 24'hF80069, 0, P_DATA0, 0, -1);
    applyStimulus("oldAddrIgnored", 24'hF80069, 0, P_DATA0, 0, -1);
    applyStimulus("newAddrNak", 24'hF80769, 0, P_DATA0, 0, -1);

    resetDut();
    applyStimulus("nakNoStatus", 24'hF80069, 0, P_DATA0, 0, -1);
    applyStimulus("badPidCompl", 24'hF8002E, 0, P_DATA0, 0, -1);

    // Unsupported request stalls until the next good SETUP
    setPayload(8'h80, 8'h06, 8'h00, 8'h12);
    applyStimulus("getDesc", 24'hF8002D, 8, P_DATA0, 0, -1);
    applyStimulus("inStall", 24'hF80069, 0, P_DATA0, 0, -1);
    applyStimulus("outStall", 24'hF800E1, 2, P_DATA1, 0, -1);
    setPayload(8'h00, 8'h09, 8'h01, 8'h00);
    applyStimulus("setConfig", 24'hF8002D, 8, P_DATA0, 0, -1);
    applyStimulus("configZlp", 24'hF80069, 0, P_DATA0, 0, -1);

    // Malformed SETUP packets get no answer
    applyStimulus("setupShort", 24'hF8002D, 7, P_DATA0, 0, -1);
    applyStimulus("setupData1", 24'hF8002D, 8, P_DATA1, 0, -1);
    applyStimulus("setupCorrupt", 24'hF8002D, 4, P_DATA0, 1, -1);
    applyStimulus("afterCorrupt", 24'hF80069, 0, P_DATA0, 0, -1);

    // Aborted status stage keeps the pending address; a retry commits it
    setPayload(8'h00, 8'h05, 8'h12, 8'h00);
    applyStimulus("setAddr12", 24'hF8002D, 8, P_DATA0, 0, -1);
    applyStimulus("zlpAbort", 24'hF80069, 0, P_DATA0, 0, 1);
    applyStimulus("zlpRetry", 24'hF80069, 0, P_DATA0, 0, -1);
    applyStimulus("addr12Nak", mkTok(P_IN, 7'h12, 4'd0), 0, P_DATA0, 0, -1);

    // Reset in the middle of a status packet clears everything immediately
    setPayload(8'h01, 8'h0B, 8'h00, 8'h00);
    applyStimulus("setIface", mkTok(P_SETUP, 7'h12, 4'd0), 8, P_DATA0, 0, -1);
    sendToken(mkTok(P_IN, 7'h12, 4'd0));
    checkOutput("midRst.first", 32'(data_o), 32'(P_DATA1));
    data_o_strb = 1; @(negedge clk); data_o_strb = 0;
    nrst = 1'b1;
    #1;
    checkOutput("midRst.ss", 32'(data_o_start_stop), 32'd0);
    checkOutput("midRst.data", 32'(data_o), 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    modelReset();
    @(negedge clk);
    applyStimulus("afterRstNak", 24'hF80069, 0, P_DATA0, 0, -1);

    // Randomized transactions against the model
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      fa = -1; em = 0; nB = 0; dp = P_DATA0;
      em = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      for (int i = 0; i < 10; i++) payload[i] = 8'($urandom_range(0, 255));
      if (kind < 4) begin
        tp = P_SETUP;
        case ($urandom_range(0, 5))
          0, 1: payload[0] = 8'h00;
          2: payload[0] = 8'h80;
          3: payload[0] = 8'h01;
          4: payload[0] = 8'h21;
          default: payload[0] = 8'hC0;
        endcase
        case ($urandom_range(0, 3))
          0, 1: payload[1] = 8'h05;
          2: payload[1] = 8'h09;
          default: payload[1] = 8'h06;
        endcase
        if ($urandom_range(0, 1) == 0) begin payload[6] = 8'h00; payload[7] = 8'h00; end
        nB = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 7 : 9) : 8;
        dp = ($urandom_range(0, 5) == 0) ? P_DATA1 : P_DATA0;
      end else if (kind < 6) begin
        tp = P_OUT;
        nB = $urandom_range(0, 10);
        case ($urandom_range(0, 4))
          0, 1: dp = P_DATA0;
          2, 3: dp = P_DATA1;
          default: dp = P_OUT;
        endcase
      end else begin
        tp = P_IN;
        if ($urandom_range(0, 3) == 0) fa = $urandom_range(0, 2);
      end
      tok = mkTok(tp, mAddr, 4'd0);
      case ($urandom_range(0, 15))
        0: tok[14:8] = mAddr ^ 7'($urandom_range(1, 127));
        1: tok[18:15] = 4'($urandom_range(1, 15));
        2: tok[0] = ~tok[0];
        3: tok[7:0] = P_SOF;
        default: ;
      endcase
      applyStimulus($sformatf("rnd%0d", t), tok, nB, dp, em, fa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
